sequencer: RTL and testbench



---
 rtl/sequencer.sv | 86 ++++++++
 tb/tb_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/sequencer.sv
// Microcode step sequencer: fetch A, fetch B, execute; registered control-ROM address.
// Optional build macro SEQ_HALT_EN: opcode 4'b1111 at the execute step freezes the sequence until reset.
//
// state        | meaning
// STEP_EXEC    | count=0, execute address presented (also the reset state)
// STEP_FETCH_A | count=1, FETCH0_ADDR presented
// STEP_FETCH_B | count=2, FETCH1_ADDR presented
// STEP_ILLEGAL | count=3, upset only; recovers into execute
module sequencer #(
    parameter logic [3:0] FETCH0_ADDR = 4'b0000,
    parameter logic [3:0] FETCH1_ADDR = 4'b0010,
    parameter logic [3:0] EXEC_OFFSET = 4'd3
) (
    input  logic       clk,
    input  logic       reset_sequencer,
    input  logic [3:0] opcode,
    output logic [3:0] control_address
);

    typedef enum logic [1:0] {
        STEP_EXEC    = 2'd0,
        STEP_FETCH_A = 2'd1,
        STEP_FETCH_B = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    step_t      count;
    step_t      count_next;
    logic [3:0] addr_next;

`ifdef SEQ_HALT_EN
    logic halted;
    logic halted_next;
`endif

    always_ff @(posedge clk) begin
        if (reset_sequencer) begin
            count           <= STEP_EXEC;
            control_address <= 4'b0000;
`ifdef SEQ_HALT_EN
            halted          <= 1'b0;
`endif
        end else begin
            count           <= count_next;
            control_address <= addr_next;
`ifdef SEQ_HALT_EN
            halted          <= halted_next;
`endif
        end
    end

    always_comb begin
        count_next = count;
        addr_next  = control_address;
`ifdef SEQ_HALT_EN
        halted_next = halted;
`endif
        case (count)
            STEP_EXEC: begin
                count_next = STEP_FETCH_A;
                addr_next  = FETCH0_ADDR;
            end
            STEP_FETCH_A: begin
                count_next = STEP_FETCH_B;
                addr_next  = FETCH1_ADDR;
            end
            default: begin
                // Fetch B and the illegal code both enter execute; mod-16 wrap is intended.
                count_next = STEP_EXEC;
                addr_next  = opcode - EXEC_OFFSET;
`ifdef SEQ_HALT_EN
                if (opcode == 4'b1111) begin
                    halted_next = 1'b1;
                end
`endif
            end
        endcase
`ifdef SEQ_HALT_EN
        if (halted) begin
            count_next = count;
            addr_next  = control_address;
        end
`endif
    end

endmodule

// File: tb/tb_sequencer.sv
// Self-checking bench for sequencer: directed steps from the test plan, then random opcodes/resets
// against a step-by-step arithmetic reference model (honours SEQ_HALT_EN when defined).
module tb_sequencer;

    logic       clk;
    logic       reset_sequencer;
    logic [3:0] opcode;
    logic [3:0] control_address;

    int checks   = 0;
    int failures = 0;

    int         m_count = 0;
    logic [3:0] m_addr  = 4'b0000;
    bit         m_halt  = 1'b0;

    sequencer dut (
        .clk             (clk),
        .reset_sequencer (reset_sequencer),
        .opcode          (opcode),
        .control_address (control_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drive one edge, advance the model, then compare just after the edge.
    task automatic step(input bit rst, input logic [3:0] op);
        reset_sequencer = rst;
        opcode          = op;
        @(posedge clk);
        if (rst) begin
            m_count = 0;
            m_addr  = 4'b0000;
            m_halt  = 1'b0;
        end else if (!m_halt) begin
            m_count = (m_count + 1) % 3;
            if (m_count == 1)      m_addr = 4'b0000;
            else if (m_count == 2) m_addr = 4'b0010;
            else begin
                m_addr = 4'((int'(op) + 16 - 3) % 16);
`ifdef SEQ_HALT_EN
                if (op == 4'd15) m_halt = 1'b1;
`endif
            end
        end
        #1;
        check("addr", control_address, m_addr);
        check("count", {2'b00, dut.count}, 4'(m_count));
    endtask

    initial begin
        reset_sequencer = 1'b1;
        opcode          = 4'b0000;

        step(1'b1, 4'b0000);
        check("reset_addr", control_address, 4'b0000);
        check("reset_count", {2'b00, dut.count}, 4'd0);
        step(1'b0, 4'b0001);
        check("first_fetch_a", control_address, 4'b0000);
        check("first_count", {2'b00, dut.count}, 4'd1);
        step(1'b0, 4'b1010);
        check("first_fetch_b", control_address, 4'b0010);
        step(1'b0, 4'b1010);
        check("exec_1010", control_address, 4'b0111);

        step(1'b0, 4'b0101);
        check("ignore_op_a", control_address, 4'b0000);
        step(1'b0, 4'b1011);
        check("ignore_op_b", control_address, 4'b0010);
        step(1'b0, 4'b1011);
        check("exec_1011", control_address, 4'b1000);

        step(1'b0, 4'b1111); step(1'b0, 4'b1111); step(1'b0, 4'b0000);
        check("exec_0000", control_address, 4'b1101);
        step(1'b0, 4'b1111); step(1'b0, 4'b1111); step(1'b0, 4'b0010);
        check("exec_0010", control_address, 4'b1111);
        step(1'b0, 4'b0000); step(1'b0, 4'b0000); step(1'b0, 4'b0011);
        check("exec_0011", control_address, 4'b0000);

        step(1'b0, 4'b0111); step(1'b0, 4'b0111);
        check("pre_reset_count", {2'b00, dut.count}, 4'd2);
        step(1'b1, 4'b0111);
        check("mid_reset_addr", control_address, 4'b0000);
        check("mid_reset_count", {2'b00, dut.count}, 4'd0);
        step(1'b0, 4'b0000);
        check("restart_count", {2'b00, dut.count}, 4'd1);

        step(1'b0, 4'b0001); step(1'b0, 4'b1111);
        check("exec_1111", control_address, 4'b1100);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0001);
`ifdef SEQ_HALT_EN
            check("halt_hold", control_address, 4'b1100);
`endif
        end
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0000);
        check("resume_fetch_a", {2'b00, dut.count}, 4'd1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
